// File: rtl/gigahurt_fetch_pkg.sv
// Shared types and constants for the gigaHurt fetch sequencer.
package gigahurt_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/imem_fetch_ctrl_pc_reg.sv
// Fetch program counter: sync reset, redirect load, increment with natural wrap.
module pc_reg #(
  parameter int             R        = 5,
  parameter logic [R-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [R-1:0] load_pc,
  input  logic         inc,
  output logic [R-1:0] pc
);

  // Load outranks increment so a redirect always wins over a same-cycle fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + R'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, registers imem words into a one-deep slot
// toward decode, and handles redirects and HALT/resume.
module imem_fetch_ctrl
  import gigahurt_fetch_pkg::*;
#(
  parameter int           N          = 16,
  parameter int           R          = 5,
  parameter logic [R-1:0] RESET_PC   = '0,
  parameter logic [N-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic [R-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] instr_out,
  output logic [R-1:0] pc_out,
  output logic         valid_out,
  input  logic         ready_in,
  input  logic         redirect_en,
  input  logic [R-1:0] redirect_pc,
  input  logic         resume,
  output logic         halted
);

  // Handshake: a word moves to decode on a cycle with valid_out && ready_in.
  // The slot may be refilled in the same cycle it is emptied; while
  // valid_out && !ready_in the slot contents are frozen until accepted or flushed.

  fetch_state_t state, state_next;
  logic [R-1:0] fetch_pc;
  logic         slot_free;
  logic         capture;

  assign slot_free = !valid_out || ready_in;
  assign capture   = (state == FETCH) && !redirect_en && slot_free;
  assign imem_addr = fetch_pc;
  assign halted    = (state == HALT);

  pc_reg #(
    .R        (R),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (redirect_en),
    .load_pc (redirect_pc),
    .inc     (capture),
    .pc      (fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_en) begin
      state_next = FETCH;
    end else if (state == FETCH) begin
      if (capture && (imem_instr == HALT_INSTR)) begin
        state_next = HALT;
      end
    end else if (resume) begin
      state_next = FETCH;
    end
  end

  // Slot register. In HALT nothing is captured, so an accepted word simply drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (redirect_en) begin
      valid_out <= 1'b0;
    end else if (capture) begin
      instr_out <= imem_instr;
      pc_out    <= fetch_pc;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the 16-bit gigaHurt core. It owns the program counter and drives the address of the combinational instruction memory (`imem`: address in, instruction out, same cycle). It registers each fetched word into a one-deep instruction slot with a valid/ready handshake toward decode. It also handles branch/jump redirects and halts fetch on a HALT instruction until it is resumed.

## Interface
Parameters:
- `N`, 16, instruction width in bits (matches imem word)
- `R`, 5, imem address width in bits (2**R words)
- `RESET_PC`, 0, fetch address loaded on reset
- `HALT_INSTR`, 16'hFFFF, full-word encoding that stops fetch

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_addr`  out  R  address to imem; equals `fetch_pc` register, no combinational path from inputs
- `imem_instr`  in  N  imem read data for `imem_addr`, same cycle
- `instr_out`  out  N  registered instruction to decode
- `pc_out`  out  R  address `instr_out` was fetched from
- `valid_out`  out  1  `instr_out`/`pc_out` hold a live instruction
- `ready_in`  in  1  decode accepts the slot this cycle
- `redirect_en`  in  1  one-cycle request to refetch from `redirect_pc`
- `redirect_pc`  in  R  redirect target
- `resume`  in  1  one-cycle request to leave HALT
- `halted`  out  1  high while state is HALT

## Operation
- States: FETCH, HALT. Reset enters FETCH.
- Transfer rule: the slot is "free" when `!valid_out || ready_in`.
- FETCH, no redirect, slot free:
  - `instr_out <= imem_instr`, `pc_out <= fetch_pc`, `valid_out <= 1`.
  - `fetch_pc <= fetch_pc + 1`, modulo 2**R. Address 2**R-1 wraps to 0 with no flag.
  - If `imem_instr == HALT_INSTR`, go to HALT. The HALT word itself is still presented with `valid_out=1`.
- FETCH, slot not free: `fetch_pc`, `instr_out`, `pc_out` and `valid_out` all hold.
- HALT:
  - No capture; `fetch_pc` holds at HALT address + 1.
  - The slot drains normally: `valid_out` clears when the HALT word is accepted and no new word follows.
  - `resume` returns to FETCH; fetch continues from `fetch_pc`.
- Redirect has highest priority, in any state:
  - `fetch_pc <= redirect_pc`, `valid_out <= 0` (the slot is flushed even if `ready_in=1`), state goes to FETCH.
  - The target word is captured on the next cycle.
- `redirect_en` and `resume` together: redirect semantics apply.
- `resume` in FETCH is ignored.
- Outputs `instr_out` and `pc_out` are don't-care while `valid_out=0`, but they hold their last value.

## Timing
- Reset values: `fetch_pc=RESET_PC`, `imem_addr=RESET_PC`, `instr_out=0`, `pc_out=0`, `valid_out=0`, `halted=0`, state FETCH.
- Reset mid-operation discards the slot and any halt, whatever the handshake state.
- First `valid_out=1` appears one cycle after `reset` falls, carrying the word at RESET_PC.
- Throughput: one instruction per cycle while `ready_in=1`.
- Fetch latency: address in cycle k gives `instr_out` valid in cycle k+1.
- Redirect penalty: a redirect asserted in cycle k gives `valid_out=0` in cycle k+1 and the target in `instr_out` in cycle k+2.
- `halted` rises the cycle after the HALT word is captured, i.e. coincident with that word in `instr_out`.
- `halted` falls the cycle after `resume` or redirect.
- Backpressure: an instruction with `valid_out=1 && ready_in=0` remains stable, bit-exact, until accepted or flushed.

## Structure
- Package `gigahurt_fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HALT}
  - `HALT_INSTR` default constant
- One natural sub-module, `pc_reg`: the R-bit PC register with sync reset, load (redirect), increment-enable and wrap.
- The slot and the FSM stay in the top module.
- Instantiated alongside `imem`: `imem_addr` connects to `imem.pc`, and `imem.instr` connects to `imem_instr`.

## Test plan
- Reset with imem words 0..3 = 16'h1000..16'h1003 and `ready_in=1` → `pc_out`/`instr_out` = 0/1000, 1/1001, 2/1002, 3/1003 on consecutive cycles starting one cycle after reset release.
- Hold `ready_in=0` for 3 cycles at `pc_out=2` → `instr_out=16'h1002` and `imem_addr=3` stable; after release, 3/1003 follows the next cycle.
- Redirect to 5'h10 while `valid_out=1, ready_in=0` → next cycle `valid_out=0`, following cycle `pc_out=16` with word 16's data.
- Word 4 = 16'hFFFF → it is presented with `pc_out=4`; `halted=1`; `valid_out` drops after acceptance; `imem_addr` holds 5; `resume` gives `pc_out=5` two cycles later.
- Start at `RESET_PC=30` → `pc_out` sequence 30, 31, 0, 1.
- Assert `reset` while halted with a stalled slot → next cycle all outputs are at reset values; `halted=0`; fetch restarts at RESET_PC.
